// File: rtl/ifetch_queue_pkg.sv
// Shared constants for the instruction-fetch prefetch queue: parameter defaults,
// the NOP encoding presented on an empty head, and the sequential PC step.
package ifetch_queue_pkg;

    localparam int          IFQ_XLEN     = 32;
    localparam int          IFQ_DEPTH    = 4;
    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] IFQ_NOP      = 32'h0000_0013;
    localparam int unsigned IFQ_PC_INC   = 4;

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry first-word-fall-through FIFO holding {pc, instr} pairs; pointers
// carry one extra wrap bit so full and empty are distinguishable.
module ifq_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int WIDTH = 2 * IFQ_XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    // Flush wins over any push or pop issued in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues credit-limited sequential fetches, queues
// responses with their PCs, and flushes on redirect. IFQ_BYPASS_EN enables the
// empty-queue bypass of a response straight onto the deq_* outputs.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int              XLEN     = IFQ_XLEN,
    parameter int              DEPTH    = IFQ_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFQ_RESET_PC)
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req,
    output logic [XLEN-1:0]              imem_addr,
    input  logic [XLEN-1:0]              imem_rdata,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    input  logic                         deq_ready,
    output logic                         deq_valid,
    output logic [XLEN-1:0]              deq_instr,
    output logic [XLEN-1:0]              deq_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int              CW         = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] NOP        = XLEN'(IFQ_NOP);
    localparam logic [XLEN-1:0] PC_INC     = XLEN'(IFQ_PC_INC);
    localparam logic [CW:0]     CREDIT_MAX = (CW + 1)'(DEPTH);

    logic [XLEN-1:0]   r_fetch_pc;
    logic              r_inflight;
    logic [XLEN-1:0]   r_inflight_pc;

    logic              w_bypass;
    logic              w_deq_fire;
    logic [CW:0]       w_used;
    logic              w_fifo_push;
    logic              w_fifo_pop;
    logic              w_fifo_empty;
    logic [2*XLEN-1:0] w_fifo_rdata;

`ifdef IFQ_BYPASS_EN
    assign w_bypass = r_inflight & w_fifo_empty & deq_ready & ~redirect_valid;
`else
    assign w_bypass = 1'b0;
`endif

    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        deq_valid = 1'b0;
        deq_instr = NOP;
        deq_pc    = '0;
        if (!redirect_valid) begin
            if (w_bypass) begin
                deq_valid = 1'b1;
                deq_instr = imem_rdata;
                deq_pc    = r_inflight_pc;
            end else if (!w_fifo_empty) begin
                deq_valid            = 1'b1;
                {deq_pc, deq_instr}  = w_fifo_rdata;
            end
        end
    end

    assign w_deq_fire = deq_valid & deq_ready;

    // Slots already spoken for after this cycle: queued plus inflight, less the pop.
    assign w_used = {1'b0, count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_deq_fire};

    assign imem_req  = ~rst & ~redirect_valid & (w_used < CREDIT_MAX);
    assign imem_addr = r_fetch_pc;

    assign w_fifo_push = r_inflight & ~w_bypass;
    assign w_fifo_pop  = w_deq_fire & ~w_bypass;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_fetch_pc    <= r_fetch_pc + PC_INC;
                r_inflight_pc <= r_fetch_pc;
            end
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_wdata ({r_inflight_pc, imem_rdata}),
        .o_rdata (w_fifo_rdata),
        .o_empty (w_fifo_empty),
        .o_count (count)
    );

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch entries; power of two, >=2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address.
REQ-004 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port imem_req, output, 1: fetch issued this cycle.
REQ-007 SHALL have port imem_addr, output, XLEN: word-aligned fetch address.
REQ-008 SHALL have port imem_rdata, input, XLEN: synchronous memory data, valid one cycle after imem_req.
REQ-009 SHALL have port redirect_valid, input, 1: branch/jump resolved; flush and refetch.
REQ-010 SHALL have port redirect_pc, input, XLEN: new fetch target.
REQ-011 SHALL have port deq_ready, input, 1: decode accepts head entry; low = stall.
REQ-012 SHALL have port deq_valid, output, 1: head entry available.
REQ-013 SHALL have port deq_instr, output, XLEN: head instruction.
REQ-014 SHALL have port deq_pc, output, XLEN: PC of head instruction.
REQ-015 SHALL have port count, output, $clog2(DEPTH+1): occupied entries.

Function
REQ-016 SHALL assert imem_req when not redirecting and count + inflight - deq_fire < DEPTH, where deq_fire = deq_valid & deq_ready.
REQ-017 SHALL drive imem_addr = fetch_pc, and fetch_pc SHALL advance by 4 per issued request, wrapping 32'hFFFF_FFFC -> 0.
REQ-018 SHALL capture the issued address in an inflight register; next cycle, imem_rdata and that PC are enqueued together.
REQ-019 SHALL pop one entry per deq_fire, preserving program order; enqueue and dequeue in the same cycle SHALL leave count unchanged.
REQ-020 SHALL never overflow: an enqueue with count == DEPTH is impossible by REQ-016.
REQ-021 SHALL drive deq_instr = 32'h0000_0013 (NOP) and deq_pc = 0 when deq_valid is low.
REQ-022 On redirect_valid, SHALL in the same cycle deassert imem_req and block dequeue (deq_valid forced low).
REQ-023 On redirect_valid, SHALL at the next edge empty the FIFO, squash any inflight response, and load fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
REQ-024 SHALL issue the first request from redirect_pc one cycle after redirect_valid; if redirect_valid stays high, the last cycle's redirect_pc SHALL win.
REQ-025 SHALL hold imem_req high across a deq_ready-low stall until the credit limit is reached, then hold fetch_pc.

Reset
REQ-026 While rst is high, SHALL set fetch_pc = RESET_PC, count = 0, inflight = 0, FIFO pointers = 0, imem_req = 0, and deq_valid = 0.
REQ-027 A reset asserted mid-fetch SHALL discard the inflight response; the first request SHALL issue in the first cycle after rst deasserts.

Configuration
REQ-028 With IFQ_BYPASS_EN defined, a response arriving with count == 0 and deq_ready high SHALL be presented on deq_* in its arrival cycle and SHALL NOT be enqueued. Load-to-decode latency is then 1 cycle after imem_req.
REQ-029 With IFQ_BYPASS_EN undefined, every response SHALL be enqueued, and deq_valid SHALL assert no earlier than 2 cycles after imem_req.

Structure
REQ-030 A shared package SHALL hold the defaults for XLEN, DEPTH and RESET_PC, the NOP encoding 32'h0000_0013, and the PC increment constant 4.
REQ-031 Storage SHALL be one sub-module, ifq_fifo: a DEPTH x (2*XLEN) synchronous FIFO with wrap-around pointers and an extra pointer bit for full/empty.

Verification
REQ-032 Reset release, RESET_PC=0, memory[i]=i, deq_ready=1 -> addresses 0,4,8,... on consecutive cycles; deq_pc/deq_instr = 0/0, 4/1, 8/2 in order, no gaps after the first.
REQ-033 deq_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests; count saturates at 4; imem_req low; no entry lost when deq_ready rises.
REQ-034 Redirect to 32'h0000_0102 with 3 entries queued plus 1 inflight -> count=0 next cycle; inflight data dropped; next imem_addr = 32'h0000_0100; first deq_pc = 32'h0000_0100.
REQ-035 RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 rst pulsed while inflight and count=2 -> count=0 and deq_valid=0 immediately; first post-reset deq_pc = RESET_PC.
REQ-037 IFQ_BYPASS_EN defined, queue empty, deq_ready=1 -> deq_valid high 1 cycle after imem_req with count staying 0; undefined -> 2 cycles, count pulses to 1.
